banked_mem_param: RTL and testbench
===================================

BANKED_MEM_PARAM -- requirements
Module: banked_mem_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16384, words per byte bank; power of two, minimum 4.
REQ-002 SHALL have parameter FETCH_W, default 2, instructions returned per fetch; range 1..4.
REQ-003 SHALL have parameter ADDR_W, default 64, width of instruction and data address inputs.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port io_reset, input, 1, synchronous soft reset from the core.
REQ-007 SHALL have port io_ld_valid, input, 1, preload word present.
REQ-008 SHALL have port io_ld_data, input, 32, preload word, little-endian across banks 0..3.
REQ-009 SHALL have port io_ld_last, input, 1, marks the final preload word.
REQ-010 SHALL have port io_ld_ready, output, 1, preload word accepted this cycle.
REQ-011 SHALL have port io_run, output, 1, high in RUN state.
REQ-012 SHALL have port io_if_mem_instAddr, input, ADDR_W, fetch byte address.
REQ-013 SHALL have port io_mem_id_inst, output, 32*FETCH_W, slot k in bits [32k+31:32k].
REQ-014 SHALL have port io_mem_id_valid, output, 1, fetch data valid.
REQ-015 SHALL have ports io_ex_mem_dataAddr (input, ADDR_W), io_ex_mem_readEn (input, 1), io_ex_mem_writeEn (input, 1), io_ex_mem_writeData (input, 32), io_ex_mem_func3 (input, 3): RV32I load/store request.
REQ-016 SHALL have ports io_mem_lsu_data (output, 32) and io_mem_lsu_valid (output, 1): load result.
REQ-017 SHALL have port io_mem_misalign, output, 1, one-cycle pulse on a rejected access.

Function
REQ-018 SHALL implement a two-state FSM: PRELOAD, then RUN.
REQ-019 PRELOAD: io_ld_ready SHALL equal io_ld_valid, and each accepted word SHALL be written to word index cnt.
REQ-020 PRELOAD: cnt SHALL increment per accepted word, modulo DEPTH.
REQ-021 PRELOAD: an accepted word with io_ld_last=1 SHALL be written and SHALL move the FSM to RUN on the same edge.
REQ-022 PRELOAD: fetch and LSU requests SHALL be ignored and all valid outputs SHALL stay 0.
REQ-023 RUN: io_ld_ready SHALL be 0 and preload inputs SHALL be ignored; no path leads back to PRELOAD except reset.
REQ-024 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, giving modulo-DEPTH wrap.
REQ-025 Fetch (RUN, every cycle) SHALL return slot k = word (idx+k) mod DEPTH one cycle after the address, with io_mem_id_valid=1.
REQ-026 Fetch SHALL ignore instAddr[1:0].
REQ-027 Stores SHALL be selected by func3: SB=000 sets one byte enable at addr[1:0]; SH=001 sets two at addr[1]; SW=010 sets all four.
REQ-028 Store data SHALL be shifted left by 8*addr[1:0] before being written to the enabled banks.
REQ-029 Loads (readEn=1) SHALL put the result on io_mem_lsu_data one cycle later with io_mem_lsu_valid=1.
REQ-030 Load formats: LB=000 and LH=001 sign-extend, LW=010 full word, LBU=100 and LHU=101 zero-extend.
REQ-031 Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) and any other func3 SHALL suppress the write; a load SHALL return 0 with valid=1; io_mem_misalign SHALL pulse one cycle later.
REQ-032 Read and write to the same word in the same cycle SHALL be read-first: load and fetch return the pre-store data, and the store is visible from the next cycle.
REQ-033 readEn and writeEn both high SHALL perform the store and the load, read-first.
REQ-034 With neither readEn nor writeEn high, io_mem_lsu_valid SHALL be 0 next cycle and io_mem_lsu_data SHALL hold its last value.
REQ-035 io_reset=1 SHALL clear the output registers (valids, inst, lsu_data, misalign) at the next edge.
REQ-036 io_reset=1 SHALL suppress stores that cycle.
REQ-037 io_reset SHALL NOT change FSM state, cnt or memory.

Reset
REQ-038 reset SHALL asynchronously force FSM=PRELOAD, cnt=0 and all outputs to 0 (io_run=0, io_ld_ready combinationally 0).
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 reset asserted mid-preload SHALL restart the load at word 0.
REQ-041 reset asserted in RUN SHALL discard any in-flight load or fetch result.

Verification
REQ-042 Preload 0x11223344, 0x55667788, last on 3rd word 0xAABBCCDD -> io_run=1 after 3rd edge; fetch addr 0x4 with FETCH_W=2 -> next cycle inst0=0x55667788, inst1=0xAABBCCDD.
REQ-043 After a store SW 0x80000000 to addr 0x10: LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF8000; LHU 0x12 -> 0x00008000.
REQ-044 SB 0xEE to addr 0x11 over word 0x00000000 -> next LW 0x10 returns 0x0000EE00.
REQ-045 SH to addr 0x13 -> memory unchanged, io_mem_misalign=1 for one cycle; LW to 0x6 -> data 0 with valid=1 and misalign pulse.
REQ-046 Same-cycle SW 0x12345678 and LW to addr 0x20 holding 0xDEADBEEF -> load returns 0xDEADBEEF; following LW returns 0x12345678.
REQ-047 DEPTH=4, fetch at addr 0xC -> inst1 = word 0; reset pulse after 2 of 4 preload words -> io_run=0, next accepted word written to index 0.

Source files
------------

// File: rtl/banked_mem_param.sv
// Byte-banked instruction/data memory: preloaded word-by-word, then serves
// multi-slot instruction fetch and RV32I byte/half/word loads and stores.
module banked_mem_param #(
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_reset,
  input  logic                  io_ld_valid,
  input  logic [31:0]           io_ld_data,
  input  logic                  io_ld_last,
  output logic                  io_ld_ready,
  output logic                  io_run,
  input  logic [ADDR_W-1:0]     io_if_mem_instAddr,
  output logic [32*FETCH_W-1:0] io_mem_id_inst,
  output logic                  io_mem_id_valid,
  input  logic [ADDR_W-1:0]     io_ex_mem_dataAddr,
  input  logic                  io_ex_mem_readEn,
  input  logic                  io_ex_mem_writeEn,
  input  logic [31:0]           io_ex_mem_writeData,
  input  logic [2:0]            io_ex_mem_func3,
  output logic [31:0]           io_mem_lsu_data,
  output logic                  io_mem_lsu_valid,
  output logic                  io_mem_misalign
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned INST_W = 32 * FETCH_W;

  typedef enum logic {ST_PRELOAD = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt;
  logic [7:0]         mem [4][DEPTH];

  logic [IDX_W-1:0]   iidx, didx;
  logic [1:0]         off;
  logic               ld_acc_c, st_en_c, st_bad_c, ld_bad_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c, rword_c, rsh_c, ld_fmt_c;
  logic [INST_W-1:0]  fetch_c;
  logic               unused;

  assign iidx   = io_if_mem_instAddr[IDX_W+1:2];
  assign didx   = io_ex_mem_dataAddr[IDX_W+1:2];
  assign off    = io_ex_mem_dataAddr[1:0];
  assign unused = ^{io_if_mem_instAddr[ADDR_W-1:IDX_W+2], io_if_mem_instAddr[1:0],
                    io_ex_mem_dataAddr[ADDR_W-1:IDX_W+2], rsh_c[31:16]};

  // Preload words are never taken while the async reset is held
  assign ld_acc_c = (state == ST_PRELOAD) && io_ld_valid && !reset;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_PRELOAD;
    else       state <= state_nxt;
  end

  // FSM next state: RUN is only left through reset
  always_comb begin
    state_nxt = state;
    if (ld_acc_c && io_ld_last) state_nxt = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    io_ld_ready = ld_acc_c;
    io_run      = (state == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (ld_acc_c) cnt <= cnt + IDX_W'(1);
  end

  // Fetch slots wrap modulo DEPTH
  always_comb begin
    fetch_c = '0;
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      fetch_c[32*k +: 32] = {mem[3][iidx + IDX_W'(k)], mem[2][iidx + IDX_W'(k)],
                             mem[1][iidx + IDX_W'(k)], mem[0][iidx + IDX_W'(k)]};
    end
  end

  // Store byte enables and alignment
  always_comb begin
    st_bad_c = 1'b1;
    be_c     = 4'b0000;
    case (io_ex_mem_func3)
      3'b000: begin st_bad_c = 1'b0;          be_c = 4'b0001 << off; end
      3'b001: begin st_bad_c = off[0];        be_c = off[1] ? 4'b1100 : 4'b0011; end
      3'b010: begin st_bad_c = (off != 2'b00); be_c = 4'b1111; end
      default: ;
    endcase
  end

  assign wdata_c = io_ex_mem_writeData << {off, 3'b000};
  assign st_en_c = (state == ST_RUN) && io_ex_mem_writeEn && !io_reset && !st_bad_c;

  // Load extraction and alignment
  assign rword_c = {mem[3][didx], mem[2][didx], mem[1][didx], mem[0][didx]};
  assign rsh_c   = rword_c >> {off, 3'b000};

  always_comb begin
    ld_bad_c = 1'b1;
    ld_fmt_c = '0;
    case (io_ex_mem_func3)
      3'b000: begin ld_bad_c = 1'b0;           ld_fmt_c = {{24{rsh_c[7]}}, rsh_c[7:0]}; end
      3'b001: begin ld_bad_c = off[0];         ld_fmt_c = {{16{rsh_c[15]}}, rsh_c[15:0]}; end
      3'b010: begin ld_bad_c = (off != 2'b00); ld_fmt_c = rword_c; end
      3'b100: begin ld_bad_c = 1'b0;           ld_fmt_c = {24'h0, rsh_c[7:0]}; end
      3'b101: begin ld_bad_c = off[0];         ld_fmt_c = {16'h0, rsh_c[15:0]}; end
      default: ;
    endcase
  end

  // Memory array is deliberately not reset
  always_ff @(posedge clock) begin
    if (ld_acc_c) begin
      for (int b = 0; b < 4; b++) mem[b][cnt] <= io_ld_data[8*b +: 8];
    end else if (st_en_c) begin
      for (int b = 0; b < 4; b++) if (be_c[b]) mem[b][didx] <= wdata_c[8*b +: 8];
    end
  end

  // Registered fetch / load / misalign results; reads see pre-store data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_mem_id_valid  <= 1'b0;
      io_mem_id_inst   <= '0;
      io_mem_lsu_valid <= 1'b0;
      io_mem_lsu_data  <= '0;
      io_mem_misalign  <= 1'b0;
    end else if (io_reset) begin
      io_mem_id_valid  <= 1'b0;
      io_mem_id_inst   <= '0;
      io_mem_lsu_valid <= 1'b0;
      io_mem_lsu_data  <= '0;
      io_mem_misalign  <= 1'b0;
    end else if (state == ST_RUN) begin
      io_mem_id_valid  <= 1'b1;
      io_mem_id_inst   <= fetch_c;
      io_mem_lsu_valid <= io_ex_mem_readEn;
      if (io_ex_mem_readEn) io_mem_lsu_data <= ld_bad_c ? 32'h0 : ld_fmt_c;
      io_mem_misalign  <= (io_ex_mem_readEn && ld_bad_c) || (io_ex_mem_writeEn && st_bad_c);
    end else begin
      io_mem_id_valid  <= 1'b0;
      io_mem_lsu_valid <= 1'b0;
      io_mem_misalign  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banked_mem_param.sv
// Scoreboard bench for banked_mem_param: default-size instance plus a DEPTH=4
// instance for wrap and mid-preload reset behaviour.
module tb_banked_mem_param;

  logic        clock = 1'b0;
  logic        rst, io_reset, ld_valid, ld_last, rd_en, wr_en;
  logic [31:0] ld_data, wr_data;
  logic [63:0] inst_addr, data_addr;
  logic [2:0]  func3;
  logic        ld_ready, run, id_valid, lsu_valid, misalign;
  logic [63:0] inst;
  logic [31:0] lsu_data;

  logic        s_rst, s_ld_valid, s_ld_last;
  logic [31:0] s_ld_data;
  logic [63:0] s_inst_addr;
  logic        s_ld_ready, s_run, s_id_valid, s_lsu_valid, s_misalign;
  logic [63:0] s_inst;
  logic [31:0] s_lsu_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] lsu_q[$];
  logic [63:0] inst_q[$];

  always #5 clock = ~clock;

  banked_mem_param u_dut (
    .clock(clock), .reset(rst), .io_reset(io_reset),
    .io_ld_valid(ld_valid), .io_ld_data(ld_data), .io_ld_last(ld_last),
    .io_ld_ready(ld_ready), .io_run(run),
    .io_if_mem_instAddr(inst_addr), .io_mem_id_inst(inst), .io_mem_id_valid(id_valid),
    .io_ex_mem_dataAddr(data_addr), .io_ex_mem_readEn(rd_en), .io_ex_mem_writeEn(wr_en),
    .io_ex_mem_writeData(wr_data), .io_ex_mem_func3(func3),
    .io_mem_lsu_data(lsu_data), .io_mem_lsu_valid(lsu_valid), .io_mem_misalign(misalign)
  );

  banked_mem_param #(.DEPTH(4)) u_small (
    .clock(clock), .reset(s_rst), .io_reset(1'b0),
    .io_ld_valid(s_ld_valid), .io_ld_data(s_ld_data), .io_ld_last(s_ld_last),
    .io_ld_ready(s_ld_ready), .io_run(s_run),
    .io_if_mem_instAddr(s_inst_addr), .io_mem_id_inst(s_inst), .io_mem_id_valid(s_id_valid),
    .io_ex_mem_dataAddr(64'h0), .io_ex_mem_readEn(1'b0), .io_ex_mem_writeEn(1'b0),
    .io_ex_mem_writeData(32'h0), .io_ex_mem_func3(3'b000),
    .io_mem_lsu_data(s_lsu_data), .io_mem_lsu_valid(s_lsu_valid), .io_mem_misalign(s_misalign)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_lsu(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [31:0] d);
    @(negedge clock);
    rd_en = rd; wr_en = wr; func3 = f3; data_addr = a; wr_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_rst = 1'b1;
    repeat (2) @(negedge clock);
    ld_valid = 1'b1;
    #1;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL rst_run act=%0h req=0", run); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready act=%0h req=0", ld_ready); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid act=%0h req=0", id_valid); end
    total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL rst_lsu_valid act=%0h req=0", lsu_valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign act=%0h req=0", misalign); end
    total++; if (lsu_data !== 32'h0) begin bad++; $display("FAIL rst_lsu_data act=%h req=0", lsu_data); end
    total++; if (inst !== 64'h0) begin bad++; $display("FAIL rst_inst act=%h req=0", inst); end
    ld_valid = 1'b0;
    @(negedge clock);
    rst = 1'b0; s_rst = 1'b0;
  endtask

  task automatic test_preload();
    logic [31:0] words [3] = '{32'h11223344, 32'h55667788, 32'hAABBCCDD};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
      #1;
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL pre_ready[%0d] act=%0h req=1", i, ld_ready); end
      total++; if (run !== 1'b0) begin bad++; $display("FAIL pre_run[%0d] act=%0h req=0", i, run); end
      step();
    end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL pre_run_after act=%0h req=1", run); end
    @(negedge clock);
    ld_data = 32'hFFFFFFFF; ld_last = 1'b1;
    #1;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL run_ld_ready act=%0h req=0", ld_ready); end
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic test_fetch();
    logic [63:0] addrs [4] = '{64'h4, 64'h7, 64'h0, 64'h10004};
    logic [63:0] exps  [4] = '{{32'hAABBCCDD, 32'h55667788}, {32'hAABBCCDD, 32'h55667788},
                               {32'h55667788, 32'h11223344}, {32'hAABBCCDD, 32'h55667788}};
    logic [63:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      inst_addr = addrs[i];
      inst_q.push_back(exps[i]);
      step();
      e = inst_q.pop_front();
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid[%0d] act=%0h req=1", i, id_valid); end
      total++; if (inst !== e) begin bad++; $display("FAIL fetch_inst[%0d] act=%h req=%h", i, inst, e); end
    end
  endtask

  task automatic test_load_formats();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [63:0] as   [5] = '{64'h13, 64'h13, 64'h12, 64'h12, 64'h10};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000, 32'h80000000};
    logic [31:0] e;
    drive_lsu(1'b0, 1'b1, 3'b010, 64'h10, 32'h80000000);
    step();
    for (int i = 0; i < 5; i++) begin
      drive_lsu(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      lsu_q.push_back(exps[i]);
      step();
      e = lsu_q.pop_front();
      total++; if (lsu_valid !== 1'b1) begin bad++; $display("FAIL fmt_valid[%0d] act=%0h req=1", i, lsu_valid); end
      total++; if (lsu_data !== e) begin bad++; $display("FAIL fmt_data[%0d] act=%h req=%h", i, lsu_data, e); end
      total++; if (misalign !== 1'b0) begin bad++; $display("FAIL fmt_misalign[%0d] act=%0h req=0", i, misalign); end
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] e;
    drive_lsu(1'b0, 1'b1, 3'b010, 64'h10, 32'h0);
    drive_lsu(1'b0, 1'b1, 3'b000, 64'h11, 32'hABCDEFEE);
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h10, 32'h0);
    lsu_q.push_back(32'h0000EE00);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL sb_data act=%h req=%h", lsu_data, e); end
    drive_lsu(1'b0, 1'b1, 3'b001, 64'h12, 32'h1234BEEF);
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h10, 32'h0);
    lsu_q.push_back(32'hBEEFEE00);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL sh_data act=%h req=%h", lsu_data, e); end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    drive_lsu(1'b0, 1'b1, 3'b001, 64'h13, 32'hFFFFFFFF);
    step();
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_sh_pulse act=%0h req=1", misalign); end
    total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL mis_sh_valid act=%0h req=0", lsu_valid); end
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h10, 32'h0);
    lsu_q.push_back(32'hBEEFEE00);
    step();
    e = lsu_q.pop_front();
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse_end act=%0h req=0", misalign); end
    total++; if (lsu_data !== e) begin bad++; $display("FAIL mis_sh_nowrite act=%h req=%h", lsu_data, e); end
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h6, 32'h0);
    lsu_q.push_back(32'h0);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_valid !== 1'b1) begin bad++; $display("FAIL mis_lw_valid act=%0h req=1", lsu_valid); end
    total++; if (lsu_data !== e) begin bad++; $display("FAIL mis_lw_data act=%h req=%h", lsu_data, e); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_lw_pulse act=%0h req=1", misalign); end
    drive_lsu(1'b1, 1'b0, 3'b011, 64'h10, 32'h0);
    lsu_q.push_back(32'h0);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL mis_f3_data act=%h req=%h", lsu_data, e); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_f3_pulse act=%0h req=1", misalign); end
  endtask

  task automatic test_read_first();
    logic [31:0] e;
    drive_lsu(1'b0, 1'b1, 3'b010, 64'h20, 32'hDEADBEEF);
    step();
    drive_lsu(1'b1, 1'b1, 3'b010, 64'h20, 32'h12345678);
    inst_addr = 64'h20;
    lsu_q.push_back(32'hDEADBEEF);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL rf_load act=%h req=%h", lsu_data, e); end
    total++; if (inst[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rf_fetch act=%h req=deadbeef", inst[31:0]); end
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h20, 32'h0);
    lsu_q.push_back(32'h12345678);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL rf_after act=%h req=%h", lsu_data, e); end
    drive_lsu(1'b0, 1'b0, 3'b010, 64'h0, 32'h0);
    step();
    total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL hold_valid act=%0h req=0", lsu_valid); end
    total++; if (lsu_data !== 32'h12345678) begin bad++; $display("FAIL hold_data act=%h req=12345678", lsu_data); end
  endtask

  task automatic test_soft_reset();
    logic [31:0] e;
    drive_lsu(1'b1, 1'b1, 3'b010, 64'h20, 32'hCAFEF00D);
    io_reset = 1'b1;
    step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL srst_id_valid act=%0h req=0", id_valid); end
    total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL srst_lsu_valid act=%0h req=0", lsu_valid); end
    total++; if (lsu_data !== 32'h0) begin bad++; $display("FAIL srst_lsu_data act=%h req=0", lsu_data); end
    total++; if (inst !== 64'h0) begin bad++; $display("FAIL srst_inst act=%h req=0", inst); end
    total++; if (run !== 1'b1) begin bad++; $display("FAIL srst_run act=%0h req=1", run); end
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h20, 32'h0);
    io_reset = 1'b0;
    lsu_q.push_back(32'h12345678);
    step();
    e = lsu_q.pop_front();
    total++; if (lsu_data !== e) begin bad++; $display("FAIL srst_nostore act=%h req=%h", lsu_data, e); end
  endtask

  task automatic test_hard_reset_run();
    logic [63:0] e;
    drive_lsu(1'b1, 1'b0, 3'b010, 64'h20, 32'h0);
    #1 rst = 1'b1;
    #1;
    total++; if (run !== 1'b0) begin bad++; $display("FAIL hrst_run act=%0h req=0", run); end
    step();
    total++; if (lsu_valid !== 1'b0) begin bad++; $display("FAIL hrst_lsu_valid act=%0h req=0", lsu_valid); end
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL hrst_id_valid act=%0h req=0", id_valid); end
    drive_lsu(1'b0, 1'b0, 3'b000, 64'h0, 32'h0);
    rst = 1'b0;
    @(negedge clock);
    ld_valid = 1'b1; ld_data = 32'h01020304; ld_last = 1'b1;
    step();
    total++; if (run !== 1'b1) begin bad++; $display("FAIL hrst_rerun act=%0h req=1", run); end
    @(negedge clock);
    ld_valid = 1'b0; ld_last = 1'b0; inst_addr = 64'h0;
    inst_q.push_back({32'h55667788, 32'h01020304});
    step();
    e = inst_q.pop_front();
    total++; if (inst !== e) begin bad++; $display("FAIL hrst_mem_kept act=%h req=%h", inst, e); end
  endtask

  task automatic test_small_depth();
    logic [31:0] bw [4] = '{32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3};
    logic [63:0] e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      s_ld_valid = 1'b1; s_ld_data = 32'hA0A0A0A0 + 32'(i); s_ld_last = 1'b0;
      step();
    end
    @(negedge clock);
    s_ld_valid = 1'b0; s_rst = 1'b1;
    #1;
    total++; if (s_run !== 1'b0) begin bad++; $display("FAIL small_rst_run act=%0h req=0", s_run); end
    @(negedge clock);
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_ld_valid = 1'b1; s_ld_data = bw[i]; s_ld_last = (i == 3);
      #1;
      total++; if (s_ld_ready !== 1'b1) begin bad++; $display("FAIL small_ready[%0d] act=%0h req=1", i, s_ld_ready); end
      step();
    end
    total++; if (s_run !== 1'b1) begin bad++; $display("FAIL small_run act=%0h req=1", s_run); end
    @(negedge clock);
    s_ld_valid = 1'b0; s_ld_last = 1'b0; s_inst_addr = 64'hC;
    inst_q.push_back({bw[0], bw[3]});
    step();
    e = inst_q.pop_front();
    total++; if (s_inst !== e) begin bad++; $display("FAIL small_wrap act=%h req=%h", s_inst, e); end
    @(negedge clock);
    s_inst_addr = 64'h10;
    inst_q.push_back({bw[1], bw[0]});
    step();
    e = inst_q.pop_front();
    total++; if (s_inst !== e) begin bad++; $display("FAIL small_hibits act=%h req=%h", s_inst, e); end
  endtask

  initial begin
    rst = 1'b1; s_rst = 1'b1; io_reset = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    rd_en = 1'b0; wr_en = 1'b0; wr_data = '0; func3 = '0; data_addr = '0; inst_addr = '0;
    s_ld_valid = 1'b0; s_ld_last = 1'b0; s_ld_data = '0; s_inst_addr = '0;
    test_reset();
    test_preload();
    test_fetch();
    test_load_formats();
    test_partial_store();
    test_misalign();
    test_read_first();
    test_soft_reset();
    test_hard_reset_run();
    test_small_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
